pong_game_ctrl: RTL and testbench

- Game-flow controller for the Pong datapath (paddle/ball translation, collision detect, VGA draw).
- Sequences the game: IDLE, SERVE, PLAY, POINT, OVER.
- Gates ball/paddle motion with a once-per-frame enable and owns the score counters.
- Escalates ball speed on paddle hits.
- Sits between the VGA driver's frame tick and the motion/collision logic; score outputs feed the HEX/LED display scheduler.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_game_ctrl_if.sv | 43 ++++
 rtl/pong_frame_timer.sv | 41 ++++
 rtl/pong_game_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state and winner encodings, counter widths,
// and screen geometry shared with the motion/collision logic.
package pong_pkg;

    localparam int unsigned SCORE_W       = 4;
    localparam int unsigned SPEED_W       = 3;
    localparam int unsigned SCREEN_WIDTH  = 640;
    localparam int unsigned SCREEN_HEIGHT = 480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Game-controller signal bundle between the frame/collision side and the
// controller. pause_sw exists only when PONG_PAUSE_EN is defined.
interface pong_game_ctrl_if #(
    parameter int unsigned SCORE_W = pong_pkg::SCORE_W
);

    logic                          frame_tick;
    logic                          start_btn;
    logic                          hit_p1;
    logic                          hit_p2;
    logic                          miss_left;
    logic                          miss_right;
`ifdef PONG_PAUSE_EN
    logic                          pause_sw;
`endif
    logic                          move_en;
    logic [pong_pkg::SPEED_W-1:0]  ball_speed;
    logic                          serve_req;
    logic                          serve_dir;
    logic [SCORE_W-1:0]            p1_score;
    logic [SCORE_W-1:0]            p2_score;
    logic [1:0]                    winner;
    logic [2:0]                    state;

    modport master (
`ifdef PONG_PAUSE_EN
        output pause_sw,
`endif
        output frame_tick, start_btn, hit_p1, hit_p2, miss_left, miss_right,
        input  move_en, ball_speed, serve_req, serve_dir,
        input  p1_score, p2_score, winner, state
    );

    modport slave (
`ifdef PONG_PAUSE_EN
        input  pause_sw,
`endif
        input  frame_tick, start_btn, hit_p1, hit_p2, miss_left, miss_right,
        output move_en, ball_speed, serve_req, serve_dir,
        output p1_score, p2_score, winner, state
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter: counts frame_tick pulses after a load and
// raises a one-cycle expire pulse on the tick that exhausts it. A load of 0
// or 1 expires on the first tick. Load takes priority over a same-cycle tick.
module pong_frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic         armed_q;

    // Countdown with single-shot expiry; disarmed until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            armed_q <= 1'b0;
            expire  <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (load) begin
                count_q <= load_val;
                armed_q <= 1'b1;
            end else if (frame_tick && armed_q) begin
                if (count_q <= W'(1)) begin
                    count_q <= '0;
                    armed_q <= 1'b0;
                    expire  <= 1'b1;
                end else begin
                    count_q <= count_q - W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences IDLE/SERVE/PLAY/POINT/OVER, gates
// motion once per frame, keeps scores and escalates ball speed on hits.
// Optional macro PONG_PAUSE_EN adds pause_sw and the PAUSE state.
module pong_game_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SCORE_W      = pong_pkg::SCORE_W,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 120,
    parameter int unsigned SPEEDUP_HITS = 4,
    parameter int unsigned MAX_SPEED    = 4
) (
    input  logic              pixel_clk,
    input  logic              rst,
    pong_game_ctrl_if.slave   bus
);

    import pong_pkg::*;

    localparam int unsigned TMAX    = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned TIMER_W = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam int unsigned HIT_W   = (SPEEDUP_HITS < 2) ? 1 : $clog2(SPEEDUP_HITS + 1);

    state_t               state_q;
    winner_t              winner_q;
    logic                 start_prev;
    logic [SCORE_W-1:0]   p1_q;
    logic [SCORE_W-1:0]   p2_q;
    logic [SPEED_W-1:0]   speed_q;
    logic [HIT_W-1:0]     hit_cnt_q;
    logic                 serve_dir_q;
    logic                 move_en_q;
    logic                 serve_req_q;

    logic                 start_rise_c;
    logic                 hit_c;
    logic                 miss_c;
    logic                 pause_c;
    logic                 win_c;
    logic                 tmr_load_c;
    logic [TIMER_W-1:0]   tmr_val_c;
    logic                 tmr_expire;

    // Input decode and frame-timer load requests, aligned with state changes.
    always_comb begin
        start_rise_c = bus.start_btn & ~start_prev;
        hit_c        = bus.hit_p1 | bus.hit_p2;
        miss_c       = bus.miss_left | bus.miss_right;
`ifdef PONG_PAUSE_EN
        pause_c      = bus.pause_sw;
`else
        pause_c      = 1'b0;
`endif
        win_c        = (p1_q == SCORE_W'(WIN_SCORE)) || (p2_q == SCORE_W'(WIN_SCORE));
        tmr_load_c   = 1'b0;
        tmr_val_c    = TIMER_W'(SERVE_FRAMES);
        case (state_q)
            ST_IDLE, ST_OVER: tmr_load_c = start_rise_c;
            ST_PLAY: begin
                if (miss_c) begin
                    tmr_load_c = 1'b1;
                    tmr_val_c  = TIMER_W'(POINT_FRAMES);
                end
            end
            ST_POINT: tmr_load_c = tmr_expire && !win_c;
            default: ;
        endcase
    end

    pong_frame_timer #(
        .W          (TIMER_W)
    ) u_timer (
        .clk        (pixel_clk),
        .rst        (rst),
        .load       (tmr_load_c),
        .load_val   (tmr_val_c),
        .frame_tick (bus.frame_tick),
        .expire     (tmr_expire)
    );

    // Game FSM with registered outputs; misses outrank pause and hits.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            winner_q    <= WIN_NONE;
            start_prev  <= 1'b1;
            p1_q        <= '0;
            p2_q        <= '0;
            speed_q     <= SPEED_W'(1);
            hit_cnt_q   <= '0;
            serve_dir_q <= 1'b1;
            move_en_q   <= 1'b0;
            serve_req_q <= 1'b0;
        end else begin
            start_prev  <= bus.start_btn;
            move_en_q   <= 1'b0;
            serve_req_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_rise_c) begin
                        p1_q      <= '0;
                        p2_q      <= '0;
                        winner_q  <= WIN_NONE;
                        speed_q   <= SPEED_W'(1);
                        hit_cnt_q <= '0;
                        state_q   <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (tmr_expire) begin
                        serve_req_q <= 1'b1;
                        state_q     <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bus.miss_left) begin
                        if (p2_q != {SCORE_W{1'b1}}) p2_q <= p2_q + SCORE_W'(1);
                        serve_dir_q <= 1'b0;
                        state_q     <= ST_POINT;
                    end else if (bus.miss_right) begin
                        if (p1_q != {SCORE_W{1'b1}}) p1_q <= p1_q + SCORE_W'(1);
                        serve_dir_q <= 1'b1;
                        state_q     <= ST_POINT;
                    end else if (pause_c) begin
                        state_q <= ST_PAUSE;
                    end else begin
                        move_en_q <= bus.frame_tick;
                        if (hit_c) begin
                            if (hit_cnt_q == HIT_W'(SPEEDUP_HITS - 1)) begin
                                hit_cnt_q <= '0;
                                if (speed_q < SPEED_W'(MAX_SPEED)) speed_q <= speed_q + SPEED_W'(1);
                            end else begin
                                hit_cnt_q <= hit_cnt_q + HIT_W'(1);
                            end
                        end
                    end
                end
                ST_POINT: begin
                    if (tmr_expire) begin
                        if (p1_q == SCORE_W'(WIN_SCORE)) begin
                            winner_q <= WIN_P1;
                            state_q  <= ST_OVER;
                        end else if (p2_q == SCORE_W'(WIN_SCORE)) begin
                            winner_q <= WIN_P2;
                            state_q  <= ST_OVER;
                        end else begin
                            speed_q   <= SPEED_W'(1);
                            hit_cnt_q <= '0;
                            state_q   <= ST_SERVE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause_c) state_q <= ST_PLAY;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.move_en    = move_en_q;
    assign bus.ball_speed = speed_q;
    assign bus.serve_req  = serve_req_q;
    assign bus.serve_dir  = serve_dir_q;
    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.winner     = winner_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. Two instances share all stimulus: the
// main one (WIN_SCORE=7) and one with WIN_SCORE=2 for the game-over path.
// Define PONG_PAUSE_EN to also exercise the pause feature.
module tb_pong_game_ctrl;

    localparam int unsigned SERVE = 3;
    localparam int unsigned POINT = 2;

    logic clk;
    logic rst;
    logic frame_tick, start_btn, hit_p1, hit_p2, miss_left, miss_right;
`ifdef PONG_PAUSE_EN
    logic pause_sw;
`endif
    int checks;
    int failures;

    pong_game_ctrl_if #(.SCORE_W(4)) bus ();
    pong_game_ctrl_if #(.SCORE_W(4)) bus_w ();

    assign bus.frame_tick   = frame_tick;
    assign bus.start_btn    = start_btn;
    assign bus.hit_p1       = hit_p1;
    assign bus.hit_p2       = hit_p2;
    assign bus.miss_left    = miss_left;
    assign bus.miss_right   = miss_right;
    assign bus_w.frame_tick = frame_tick;
    assign bus_w.start_btn  = start_btn;
    assign bus_w.hit_p1     = hit_p1;
    assign bus_w.hit_p2     = hit_p2;
    assign bus_w.miss_left  = miss_left;
    assign bus_w.miss_right = miss_right;
`ifdef PONG_PAUSE_EN
    assign bus.pause_sw     = pause_sw;
    assign bus_w.pause_sw   = pause_sw;
`endif

    pong_game_ctrl #(
        .WIN_SCORE(7), .SCORE_W(4), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT),
        .SPEEDUP_HITS(4), .MAX_SPEED(4)
    ) dut (
        .pixel_clk(clk), .rst(rst), .bus(bus.slave)
    );

    pong_game_ctrl #(
        .WIN_SCORE(2), .SCORE_W(4), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT),
        .SPEEDUP_HITS(4), .MAX_SPEED(4)
    ) dut_w (
        .pixel_clk(clk), .rst(rst), .bus(bus_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        step();
    endtask

    task automatic serve_to_play();
        repeat (SERVE) tick();
        step();
    endtask

    task automatic point_expire();
        repeat (POINT) tick();
        step();
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left = l;
        miss_right = r;
        step();
        miss_left = 1'b0;
        miss_right = 1'b0;
    endtask

    task automatic hit(input logic a, input logic b);
        hit_p1 = a;
        hit_p2 = b;
        step();
        hit_p1 = 1'b0;
        hit_p2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_btn = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_held_start state got=%0d exp=0", bus.state); end
        checks++; if (bus.ball_speed !== 3'd1) begin failures++; $display("FAIL reset_speed got=%0d exp=1", bus.ball_speed); end
        checks++; if (bus.serve_dir !== 1'b1) begin failures++; $display("FAIL reset_serve_dir got=%0d exp=1", bus.serve_dir); end
        checks++; if ({bus.move_en, bus.serve_req} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bus.move_en, bus.serve_req}); end
        checks++; if ({bus.p1_score, bus.p2_score, bus.winner} !== 10'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d/%0d exp=0/0/0", bus.p1_score, bus.p2_score, bus.winner); end
        start_btn = 1'b0;
        step();
    endtask

    task automatic test_serve();
        start_game();
        checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", bus.state); end
        tick();
        tick();
        checks++; if ({bus.state, bus.serve_req} !== {3'd1, 1'b0}) begin failures++; $display("FAIL serve_early got=%0d/%0d exp=1/0", bus.state, bus.serve_req); end
        tick();
        checks++; if ({bus.state, bus.serve_req} !== {3'd1, 1'b0}) begin failures++; $display("FAIL serve_expire got=%0d/%0d exp=1/0", bus.state, bus.serve_req); end
        step();
        checks++; if ({bus.state, bus.serve_req, bus.move_en} !== {3'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL serve_pulse got=%0d/%0d/%0d exp=2/1/0", bus.state, bus.serve_req, bus.move_en); end
        step();
        checks++; if (bus.serve_req !== 1'b0) begin failures++; $display("FAIL serve_one_cycle got=%0d exp=0", bus.serve_req); end
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.move_en !== 1'b1) begin failures++; $display("FAIL move_en_pulse%0d got=%0d exp=1", i, bus.move_en); end
            step();
            checks++; if (bus.move_en !== 1'b0) begin failures++; $display("FAIL move_en_drop%0d got=%0d exp=0", i, bus.move_en); end
        end
    endtask

    task automatic test_speedup();
        logic [2:0] exp;
        for (int i = 1; i <= 9; i++) begin
            hit(1'b1, 1'b0);
            exp = (i >= 8) ? 3'd3 : (i >= 4) ? 3'd2 : 3'd1;
            checks++; if (bus.ball_speed !== exp) begin failures++; $display("FAIL speed_hit%0d got=%0d exp=%0d", i, bus.ball_speed, exp); end
        end
        repeat (16) hit(1'b1, 1'b0);
        checks++; if (bus.ball_speed !== 3'd4) begin failures++; $display("FAIL speed_saturate got=%0d exp=4", bus.ball_speed); end
    endtask

    task automatic test_double_miss();
        hit_p1 = 1'b1;
        miss(1'b1, 1'b1);
        hit_p1 = 1'b0;
        checks++; if ({bus.p1_score, bus.p2_score} !== {4'd0, 4'd1}) begin failures++; $display("FAIL dmiss_scores got=%0d/%0d exp=0/1", bus.p1_score, bus.p2_score); end
        checks++; if ({bus.serve_dir, bus.state} !== {1'b0, 3'd3}) begin failures++; $display("FAIL dmiss_dir_state got=%0d/%0d exp=0/3", bus.serve_dir, bus.state); end
        tick();
        checks++; if ({bus.state, bus.move_en} !== {3'd3, 1'b0}) begin failures++; $display("FAIL point_hold got=%0d/%0d exp=3/0", bus.state, bus.move_en); end
        tick();
        step();
        checks++; if ({bus.state, bus.ball_speed} !== {3'd1, 3'd1}) begin failures++; $display("FAIL point_exit got=%0d/%0d exp=1/1", bus.state, bus.ball_speed); end
    endtask

    task automatic test_simul_hits();
        serve_to_play();
        repeat (3) hit(1'b1, 1'b1);
        checks++; if (bus.ball_speed !== 3'd1) begin failures++; $display("FAIL simul_hit3 got=%0d exp=1", bus.ball_speed); end
        hit(1'b1, 1'b1);
        checks++; if (bus.ball_speed !== 3'd2) begin failures++; $display("FAIL simul_hit4 got=%0d exp=2", bus.ball_speed); end
        repeat (3) hit(1'b0, 1'b1);
        hit_p1 = 1'b1;
        miss(1'b0, 1'b1);
        hit_p1 = 1'b0;
        checks++; if (bus.ball_speed !== 3'd2) begin failures++; $display("FAIL miss_beats_hit got=%0d exp=2", bus.ball_speed); end
        checks++; if ({bus.p1_score, bus.serve_dir, bus.state} !== {4'd1, 1'b1, 3'd3}) begin failures++; $display("FAIL miss_right got=%0d/%0d/%0d exp=1/1/3", bus.p1_score, bus.serve_dir, bus.state); end
        point_expire();
        checks++; if ({bus.state, bus.ball_speed} !== {3'd1, 3'd1}) begin failures++; $display("FAIL point2_exit got=%0d/%0d exp=1/1", bus.state, bus.ball_speed); end
    endtask

    task automatic test_reset_mid();
        serve_to_play();
        miss(1'b0, 1'b1);
        point_expire();
        serve_to_play();
        miss(1'b0, 1'b1);
        point_expire();
        repeat (4) hit(1'b1, 1'b0);
        checks++; if ({bus.state, bus.ball_speed} !== {3'd1, 3'd1}) begin failures++; $display("FAIL hit_in_serve got=%0d/%0d exp=1/1", bus.state, bus.ball_speed); end
        serve_to_play();
        miss(1'b1, 1'b0);
        point_expire();
        serve_to_play();
        repeat (4) hit(1'b1, 1'b0);
        checks++; if ({bus.p1_score, bus.p2_score, bus.ball_speed} !== {4'd3, 4'd2, 3'd2}) begin failures++; $display("FAIL pre_reset got=%0d/%0d/%0d exp=3/2/2", bus.p1_score, bus.p2_score, bus.ball_speed); end
        rst = 1'b1;
        frame_tick = 1'b1;
        step();
        rst = 1'b0;
        frame_tick = 1'b0;
        checks++; if ({bus.state, bus.p1_score, bus.p2_score, bus.ball_speed} !== {3'd0, 4'd0, 4'd0, 3'd1}) begin failures++; $display("FAIL mid_reset got=%0d/%0d/%0d/%0d exp=0/0/0/1", bus.state, bus.p1_score, bus.p2_score, bus.ball_speed); end
        checks++; if ({bus.move_en, bus.serve_req, bus.serve_dir} !== 3'b001) begin failures++; $display("FAIL mid_reset_pulses got=%b exp=001", {bus.move_en, bus.serve_req, bus.serve_dir}); end
        step();
        checks++; if ({bus.state, bus.move_en, bus.serve_req} !== {3'd0, 2'b00}) begin failures++; $display("FAIL post_reset got=%0d/%0d/%0d exp=0/0/0", bus.state, bus.move_en, bus.serve_req); end
    endtask

    task automatic test_win();
        start_game();
        serve_to_play();
        miss(1'b0, 1'b1);
        point_expire();
        serve_to_play();
        miss(1'b0, 1'b1);
        checks++; if ({bus_w.p1_score, bus_w.state} !== {4'd2, 3'd3}) begin failures++; $display("FAIL win_point got=%0d/%0d exp=2/3", bus_w.p1_score, bus_w.state); end
        point_expire();
        checks++; if ({bus_w.state, bus_w.winner} !== {3'd4, 2'd1}) begin failures++; $display("FAIL win_over got=%0d/%0d exp=4/1", bus_w.state, bus_w.winner); end
        checks++; if ({bus.state, bus.winner, bus.p1_score} !== {3'd1, 2'd0, 4'd2}) begin failures++; $display("FAIL nowin_main got=%0d/%0d/%0d exp=1/0/2", bus.state, bus.winner, bus.p1_score); end
        miss(1'b0, 1'b1);
        miss(1'b1, 1'b0);
        hit(1'b1, 1'b1);
        tick();
        checks++; if ({bus_w.p1_score, bus_w.p2_score, bus_w.state, bus_w.move_en} !== {4'd2, 4'd0, 3'd4, 1'b0}) begin failures++; $display("FAIL over_frozen got=%0d/%0d/%0d/%0d exp=2/0/4/0", bus_w.p1_score, bus_w.p2_score, bus_w.state, bus_w.move_en); end
        start_game();
        checks++; if ({bus_w.p1_score, bus_w.winner, bus_w.state} !== {4'd0, 2'd0, 3'd1}) begin failures++; $display("FAIL new_game got=%0d/%0d/%0d exp=0/0/1", bus_w.p1_score, bus_w.winner, bus_w.state); end
        checks++; if ({bus.state, bus.p1_score} !== {3'd1, 4'd2}) begin failures++; $display("FAIL start_in_serve got=%0d/%0d exp=1/2", bus.state, bus.p1_score); end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        int pulses;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        start_game();
        pause_sw = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL pause_in_serve got=%0d exp=1", bus.state); end
        pause_sw = 1'b0;
        tick();
        tick();
        step();
        checks++; if (bus.state !== 3'd2) begin failures++; $display("FAIL pause_play got=%0d exp=2", bus.state); end
        pause_sw = 1'b1;
        step();
        pulses = 0;
        repeat (5) begin
            tick();
            if (bus.move_en === 1'b1) pulses++;
        end
        repeat (4) hit(1'b1, 1'b0);
        checks++; if (pulses !== 0) begin failures++; $display("FAIL pause_move got=%0d exp=0", pulses); end
        checks++; if ({bus.state, bus.ball_speed} !== {3'd5, 3'd1}) begin failures++; $display("FAIL pause_state got=%0d/%0d exp=5/1", bus.state, bus.ball_speed); end
        pause_sw = 1'b0;
        step();
        step();
        checks++; if ({bus.state, bus.move_en} !== {3'd2, 1'b0}) begin failures++; $display("FAIL unpause got=%0d/%0d exp=2/0", bus.state, bus.move_en); end
        tick();
        checks++; if (bus.move_en !== 1'b1) begin failures++; $display("FAIL unpause_move got=%0d exp=1", bus.move_en); end
        step();
        checks++; if (bus.move_en !== 1'b0) begin failures++; $display("FAIL unpause_drop got=%0d exp=0", bus.move_en); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        frame_tick = 1'b0;
        start_btn = 1'b0;
        hit_p1 = 1'b0;
        hit_p2 = 1'b0;
        miss_left = 1'b0;
        miss_right = 1'b0;
`ifdef PONG_PAUSE_EN
        pause_sw = 1'b0;
`endif
        test_reset();
        test_serve();
        test_speedup();
        test_double_miss();
        test_simul_hits();
        test_reset_mid();
        test_win();
`ifdef PONG_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
